// File: rtl/ecc_read_decoder.sv
// ecc_read_decoder
//   Consumes fixed-latency Hamming(12,8) codewords from a memory read port.
//   It corrects single-bit errors and flags uncorrectable syndromes. Results
//   are buffered in a small FIFO and presented on a valid/ready interface.
//   Saturating error counters are kept for software.
//
//   Pipeline: stage 1 registers the codeword, the address and the syndrome.
//   Stage 2 applies the correction and pushes the result into the FIFO.
//
//   Ports
//     i_clk, i_rst_n    clock (rising edge), asynchronous active-low reset
//     i_valid           codeword valid from the memory (cannot be stalled)
//     i_code, i_addr    codeword and its address
//     i_clr_cnt         synchronous clear of counters and overflow flag
//     o_valid, i_ready  output handshake; pop on o_valid && i_ready
//     o_data, o_addr    corrected data and address of the head entry
//     o_err_corr        head entry had a corrected single-bit error
//     o_err_uncorr      head entry had an uncorrectable syndrome
//     o_corr_cnt        saturating corrected-error count
//     o_uncorr_cnt      saturating uncorrectable-error count
//     o_overflow        sticky: a result was dropped on a full FIFO
//
//   Optional feature, macro ECC_SCRUB_REQ_EN
//     o_scrub_valid     one-cycle pulse per corrected error, dropped or not
//     o_scrub_addr      address to write back
//     o_scrub_code      fully corrected codeword with parity recomputed
module ecc_read_decoder #(
  parameter int WIDTH      = 8,
  parameter int CODE_WIDTH = 12,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic [CODE_WIDTH-1:0] i_code,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_clr_cnt,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [WIDTH-1:0]      o_data,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_err_corr,
  output logic                  o_err_uncorr,
  output logic [CNT_WIDTH-1:0]  o_corr_cnt,
  output logic [CNT_WIDTH-1:0]  o_uncorr_cnt,
  output logic                  o_overflow
`ifdef ECC_SCRUB_REQ_EN
  ,
  output logic                  o_scrub_valid,
  output logic [ADDR_WIDTH-1:0] o_scrub_addr,
  output logic [CODE_WIDTH-1:0] o_scrub_code
`endif
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = WIDTH + ADDR_WIDTH + 2;

  // Syndrome is the XOR of the 1-based indices of every set position.
  function automatic logic [3:0] calc_syndrome(input logic [CODE_WIDTH-1:0] code);
    logic [3:0] s;
    s = '0;
    for (int k = 1; k <= CODE_WIDTH; k++) begin
      if (code[k-1]) s = s ^ 4'(k);
    end
    return s;
  endfunction

  // Data bits live at positions {12,11,10,9,7,6,5,3}.
  function automatic logic [WIDTH-1:0] extract_data(input logic [CODE_WIDTH-1:0] code);
    return {code[11], code[10], code[9], code[8], code[6], code[5], code[4], code[2]};
  endfunction

`ifdef ECC_SCRUB_REQ_EN
  // Re-encode from data so the write-back word carries freshly computed parity.
  function automatic logic [CODE_WIDTH-1:0] encode(input logic [WIDTH-1:0] d);
    logic p1, p2, p4, p8;
    p1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    p2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    p4 = d[1] ^ d[2] ^ d[3] ^ d[7];
    p8 = d[4] ^ d[5] ^ d[6] ^ d[7];
    return {d[7], d[6], d[5], d[4], p8, d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction
`endif

  // Stage 1 registers
  logic                  s1_valid;
  logic [CODE_WIDTH-1:0] s1_code;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [3:0]            s1_syn;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_addr  <= '0;
      s1_syn   <= '0;
    end else begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_code <= i_code;
        s1_addr <= i_addr;
        s1_syn  <= calc_syndrome(i_code);
      end
    end
  end

  // Stage 2 correction (combinational, consumed at the next edge)
  logic                  s2_corr;
  logic                  s2_uncorr;
  logic [CODE_WIDTH-1:0] s2_fixed;
  logic [WIDTH-1:0]      s2_data;

  always_comb begin
    s2_corr   = (s1_syn != 4'd0) && (s1_syn <= 4'd12);
    s2_uncorr = (s1_syn >= 4'd13);
    s2_fixed  = s1_code;
    if (s2_corr) s2_fixed = s1_code ^ (CODE_WIDTH'(1) << (s1_syn - 4'd1));
    s2_data   = extract_data(s2_fixed);
  end

  // Output FIFO. The pointers carry one extra wrap bit to tell full from empty.
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr;
  logic [PTR_W:0]     rd_ptr;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_pop;
  logic               fifo_push;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign fifo_pop   = !fifo_empty && i_ready;
  // A full FIFO still takes the write when the head leaves in the same cycle;
  // the write then lands in the slot that is just being vacated.
  assign fifo_push  = s1_valid && (!fifo_full || fifo_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (fifo_push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {s2_data, s1_addr, s2_corr, s2_uncorr};
  end

  logic [WIDTH-1:0]      head_data;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic                  head_corr;
  logic                  head_uncorr;

  assign {head_data, head_addr, head_corr, head_uncorr} = fifo_mem[rd_ptr[PTR_W-1:0]];

  // Storage is not reset, so the fields are gated to read zero while empty.
  assign o_valid      = !fifo_empty;
  assign o_data       = o_valid ? head_data   : '0;
  assign o_addr       = o_valid ? head_addr   : '0;
  assign o_err_corr   = o_valid && head_corr;
  assign o_err_uncorr = o_valid && head_uncorr;

  // Counters and the overflow flag; a clear beats any same-cycle update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_corr_cnt   <= '0;
      o_uncorr_cnt <= '0;
      o_overflow   <= 1'b0;
    end else if (i_clr_cnt) begin
      o_corr_cnt   <= '0;
      o_uncorr_cnt <= '0;
      o_overflow   <= 1'b0;
    end else begin
      if (s1_valid && s2_corr && (o_corr_cnt != '1))     o_corr_cnt   <= o_corr_cnt + 1'b1;
      if (s1_valid && s2_uncorr && (o_uncorr_cnt != '1)) o_uncorr_cnt <= o_uncorr_cnt + 1'b1;
      if (s1_valid && !fifo_push)                        o_overflow   <= 1'b1;
    end
  end

`ifdef ECC_SCRUB_REQ_EN
  // The scrub request is independent of the FIFO, so dropped entries still
  // get written back. Address and code hold their values between pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_scrub_valid <= 1'b0;
      o_scrub_addr  <= '0;
      o_scrub_code  <= '0;
    end else begin
      o_scrub_valid <= s1_valid && s2_corr;
      if (s1_valid && s2_corr) begin
        o_scrub_addr <= s1_addr;
        o_scrub_code <= encode(s2_data);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ecc_read_decoder.sv
// Self-checking bench for ecc_read_decoder. A queue-based reference model
// decodes codewords from the Hamming rules and tracks FIFO contents,
// counters and the overflow flag at the transaction level.
module tb_ecc_read_decoder;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [11:0] i_code;
  logic [4:0]  i_addr;
  logic        i_clr_cnt;
  logic        i_ready;
  logic        o_valid;
  logic [7:0]  o_data;
  logic [4:0]  o_addr;
  logic        o_err_corr;
  logic        o_err_uncorr;
  logic [15:0] o_corr_cnt;
  logic [15:0] o_uncorr_cnt;
  logic        o_overflow;
`ifdef ECC_SCRUB_REQ_EN
  logic        o_scrub_valid;
  logic [4:0]  o_scrub_addr;
  logic [11:0] o_scrub_code;
`endif

  ecc_read_decoder dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (i_valid),
    .i_code       (i_code),
    .i_addr       (i_addr),
    .i_clr_cnt    (i_clr_cnt),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_addr       (o_addr),
    .o_err_corr   (o_err_corr),
    .o_err_uncorr (o_err_uncorr),
    .o_corr_cnt   (o_corr_cnt),
    .o_uncorr_cnt (o_uncorr_cnt),
    .o_overflow   (o_overflow)
`ifdef ECC_SCRUB_REQ_EN
    ,
    .o_scrub_valid(o_scrub_valid),
    .o_scrub_addr (o_scrub_addr),
    .o_scrub_code (o_scrub_code)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [4:0] addr;
    logic       corr;
    logic       uncorr;
  } entry_t;

  localparam int DPOS[8] = '{3, 5, 6, 7, 9, 10, 11, 12};

  int errors = 0;
  int checks = 0;

  // Reference model state
  entry_t      q[$];
  logic        pipe_v;
  entry_t      pipe_e;
  logic [15:0] m_corr;
  logic [15:0] m_uncorr;
  logic        m_ovf;
`ifdef ECC_SCRUB_REQ_EN
  logic        m_scrub_v;
  logic [4:0]  m_scrub_addr;
  logic [11:0] m_scrub_code;
`endif

  function automatic logic [11:0] model_encode(input logic [7:0] d);
    logic [11:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c[DPOS[i]-1] = d[i];
    for (int b = 0; b < 4; b++) begin
      int p;
      logic par;
      p = 1 << b;
      par = 1'b0;
      for (int k = 1; k <= 12; k++) if ((k & p) != 0) par = par ^ c[k-1];
      c[p-1] = par;
    end
    return c;
  endfunction

  function automatic entry_t model_decode(input logic [11:0] code, input logic [4:0] addr);
    int s;
    logic [11:0] c;
    entry_t e;
    s = 0;
    c = code;
    for (int k = 1; k <= 12; k++) if (code[k-1]) s = s ^ k;
    e.corr   = (s >= 1) && (s <= 12);
    e.uncorr = (s >= 13);
    if (e.corr) c[s-1] = ~c[s-1];
    for (int i = 0; i < 8; i++) e.data[i] = c[DPOS[i]-1];
    e.addr = addr;
    return e;
  endfunction

  function automatic logic [11:0] rand_code();
    logic [11:0] c;
    int mode;
    mode = $urandom_range(0, 2);
    c = model_encode(8'($urandom));
    if (mode == 1) c[$urandom_range(0, 11)] = ~c[$urandom_range(0, 11)];
    if (mode == 2) c = 12'($urandom);
    return c;
  endfunction

  task automatic model_reset();
    q.delete();
    pipe_v   = 1'b0;
    m_corr   = '0;
    m_uncorr = '0;
    m_ovf    = 1'b0;
`ifdef ECC_SCRUB_REQ_EN
    m_scrub_v    = 1'b0;
    m_scrub_addr = '0;
    m_scrub_code = '0;
`endif
  endtask

  // Advance the model by one clock using the inputs driven for that edge.
  task automatic model_step();
    logic full, pop;
    full = (q.size() == 4);
    pop  = (q.size() != 0) && i_ready;
`ifdef ECC_SCRUB_REQ_EN
    m_scrub_v = 1'b0;
`endif
    if (pop) q.delete(0);
    if (pipe_v) begin
      if (!full || pop) q.push_back(pipe_e);
      else m_ovf = 1'b1;
      if (pipe_e.corr && m_corr != 16'hFFFF) m_corr++;
      if (pipe_e.uncorr && m_uncorr != 16'hFFFF) m_uncorr++;
`ifdef ECC_SCRUB_REQ_EN
      if (pipe_e.corr) begin
        m_scrub_v    = 1'b1;
        m_scrub_addr = pipe_e.addr;
        m_scrub_code = model_encode(pipe_e.data);
      end
`endif
    end
    if (i_clr_cnt) begin
      m_corr   = '0;
      m_uncorr = '0;
      m_ovf    = 1'b0;
    end
    pipe_v = i_valid;
    pipe_e = model_decode(i_code, i_addr);
  endtask

  // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic step(input logic v, input logic [11:0] c, input logic [4:0] a,
                      input logic r, input logic clr);
    i_valid   = v;
    i_code    = c;
    i_addr    = a;
    i_ready   = r;
    i_clr_cnt = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_valid = 0; i_code = 0; i_addr = 0; i_ready = 0; i_clr_cnt = 0;
    model_reset();
    @(negedge clk);
    checks++;
    if ({o_valid, o_data, o_addr, o_err_corr, o_err_uncorr} !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_out got v=%b d=%h a=%h c=%b u=%b want all 0",
               o_valid, o_data, o_addr, o_err_corr, o_err_uncorr);
    end
    checks++;
    if ({o_corr_cnt, o_uncorr_cnt, o_overflow} !== 33'h0) begin
      errors++;
      $display("[TB] FAIL reset_cnt got %h %h %b want 0", o_corr_cnt, o_uncorr_cnt, o_overflow);
    end
`ifdef ECC_SCRUB_REQ_EN
    checks++;
    if ({o_scrub_valid, o_scrub_addr, o_scrub_code} !== 18'h0) begin
      errors++;
      $display("[TB] FAIL reset_scrub got %b %h %h want 0", o_scrub_valid, o_scrub_addr, o_scrub_code);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_clean();
    step(1, 12'hA27, 5'd5, 1, 0);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL clean_latency got o_valid=%b want 0", o_valid);
    end
    step(0, 0, 0, 1, 0);
    checks++;
    if ({o_valid, o_data, o_addr, o_err_corr, o_err_uncorr} !== {1'b1, 8'hA5, 5'd5, 2'b00}) begin
      errors++;
      $display("[TB] FAIL clean_out got v=%b d=%h a=%0d c=%b u=%b want 1 a5 5 0 0",
               o_valid, o_data, o_addr, o_err_corr, o_err_uncorr);
    end
    checks++;
    if ({o_corr_cnt, o_uncorr_cnt} !== 32'h0) begin
      errors++; $display("[TB] FAIL clean_cnt got %h %h want 0 0", o_corr_cnt, o_uncorr_cnt);
    end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_single_err();
    step(1, 12'hA07, 5'd5, 1, 0);
    step(0, 0, 0, 1, 0);
    checks++;
    if ({o_valid, o_data, o_err_corr, o_err_uncorr} !== {1'b1, 8'hA5, 2'b10}) begin
      errors++;
      $display("[TB] FAIL single_out got v=%b d=%h c=%b u=%b want 1 a5 1 0",
               o_valid, o_data, o_err_corr, o_err_uncorr);
    end
    checks++;
    if (o_corr_cnt !== 16'd1) begin
      errors++; $display("[TB] FAIL single_cnt got %0d want 1", o_corr_cnt);
    end
`ifdef ECC_SCRUB_REQ_EN
    checks++;
    if ({o_scrub_valid, o_scrub_addr, o_scrub_code} !== {1'b1, 5'd5, 12'hA27}) begin
      errors++;
      $display("[TB] FAIL single_scrub got %b %0d %h want 1 5 a27", o_scrub_valid, o_scrub_addr, o_scrub_code);
    end
`endif
    step(0, 0, 0, 1, 0);
`ifdef ECC_SCRUB_REQ_EN
    checks++;
    if (o_scrub_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL single_scrub_pulse got %b want 0", o_scrub_valid);
    end
`endif
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL single_drain got o_valid=%b want 0", o_valid);
    end
  endtask

  task automatic test_uncorr();
    step(1, 12'hB07, 5'd5, 1, 0);
    step(0, 0, 0, 1, 0);
    checks++;
    if ({o_valid, o_data, o_err_corr, o_err_uncorr} !== {1'b1, 8'hB1, 2'b01}) begin
      errors++;
      $display("[TB] FAIL uncorr_out got v=%b d=%h c=%b u=%b want 1 b1 0 1",
               o_valid, o_data, o_err_corr, o_err_uncorr);
    end
    checks++;
    if ({o_uncorr_cnt, o_corr_cnt} !== {16'd1, 16'd1}) begin
      errors++; $display("[TB] FAIL uncorr_cnt got u=%0d c=%0d want 1 1", o_uncorr_cnt, o_corr_cnt);
    end
`ifdef ECC_SCRUB_REQ_EN
    checks++;
    if (o_scrub_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL uncorr_scrub got %b want 0", o_scrub_valid);
    end
`endif
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_overflow();
    entry_t exp_e[6];
    int ncorr, nunc, n;
    logic [11:0] c;
    ncorr = 0; nunc = 0; n = 0;
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) begin
      c = rand_code();
      exp_e[i] = model_decode(c, 5'(i + 8));
      if (exp_e[i].corr) ncorr++;
      if (exp_e[i].uncorr) nunc++;
      step(1, c, 5'(i + 8), 0, 0);
    end
    step(0, 0, 0, 0, 0);
    checks++;
    if ({o_overflow, o_valid} !== 2'b11) begin
      errors++; $display("[TB] FAIL ovf_flag got ovf=%b v=%b want 1 1", o_overflow, o_valid);
    end
    checks++;
    if (o_corr_cnt !== 16'(ncorr) || o_uncorr_cnt !== 16'(nunc)) begin
      errors++;
      $display("[TB] FAIL ovf_cnt got %0d %0d want %0d %0d", o_corr_cnt, o_uncorr_cnt, ncorr, nunc);
    end
    for (int i = 0; i < 8; i++) begin
      if (o_valid) begin
        checks++;
        if (n > 3 || o_data !== exp_e[n].data || o_addr !== exp_e[n].addr ||
            o_err_corr !== exp_e[n].corr || o_err_uncorr !== exp_e[n].uncorr) begin
          errors++;
          $display("[TB] FAIL ovf_order entry %0d got d=%h a=%0d want d=%h a=%0d",
                   n, o_data, o_addr, exp_e[n % 6].data, exp_e[n % 6].addr);
        end
        n++;
      end
      step(0, 0, 0, 1, 0);
    end
    checks++;
    if (n != 4) begin
      errors++; $display("[TB] FAIL ovf_drain_count got %0d want 4", n);
    end
    step(0, 0, 0, 1, 1);
    checks++;
    if ({o_overflow, o_corr_cnt, o_uncorr_cnt} !== 33'h0) begin
      errors++; $display("[TB] FAIL ovf_clear got %b %h %h want 0", o_overflow, o_corr_cnt, o_uncorr_cnt);
    end
  endtask

  task automatic test_full_pop();
    entry_t exp_e[5];
    logic [11:0] c;
    int n;
    n = 1;
    for (int i = 0; i < 5; i++) begin
      c = rand_code();
      exp_e[i] = model_decode(c, 5'(i + 20));
      step(1, c, 5'(i + 20), 0, 0);
    end
    step(0, 0, 0, 1, 0);
    checks++;
    if (o_overflow !== 1'b0) begin
      errors++; $display("[TB] FAIL fullpop_ovf got %b want 0", o_overflow);
    end
    for (int i = 0; i < 8; i++) begin
      if (o_valid) begin
        checks++;
        if (n > 4 || o_data !== exp_e[n].data || o_addr !== exp_e[n].addr ||
            o_err_corr !== exp_e[n].corr || o_err_uncorr !== exp_e[n].uncorr) begin
          errors++;
          $display("[TB] FAIL fullpop_order entry %0d got d=%h a=%0d want d=%h a=%0d",
                   n, o_data, o_addr, exp_e[n % 5].data, exp_e[n % 5].addr);
        end
        n++;
      end
      step(0, 0, 0, 1, 0);
    end
    checks++;
    if (n != 5) begin
      errors++; $display("[TB] FAIL fullpop_count got %0d want 4", n - 1);
    end
  endtask

  task automatic test_random();
    entry_t h;
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, rand_code(), 5'($urandom),
           $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
      h = '{8'h0, 5'h0, 1'b0, 1'b0};
      if (q.size() != 0) h = q[0];
      checks++;
      if (o_valid !== (q.size() != 0) || o_data !== h.data || o_addr !== h.addr ||
          o_err_corr !== h.corr || o_err_uncorr !== h.uncorr) begin
        errors++;
        $display("[TB] FAIL rand_head cyc %0d got v=%b d=%h a=%0d c=%b u=%b want v=%b d=%h a=%0d c=%b u=%b",
                 i, o_valid, o_data, o_addr, o_err_corr, o_err_uncorr,
                 q.size() != 0, h.data, h.addr, h.corr, h.uncorr);
      end
      checks++;
      if (o_corr_cnt !== m_corr || o_uncorr_cnt !== m_uncorr || o_overflow !== m_ovf) begin
        errors++;
        $display("[TB] FAIL rand_stats cyc %0d got %0d %0d %b want %0d %0d %b",
                 i, o_corr_cnt, o_uncorr_cnt, o_overflow, m_corr, m_uncorr, m_ovf);
      end
`ifdef ECC_SCRUB_REQ_EN
      checks++;
      if (o_scrub_valid !== m_scrub_v || o_scrub_addr !== m_scrub_addr || o_scrub_code !== m_scrub_code) begin
        errors++;
        $display("[TB] FAIL rand_scrub cyc %0d got %b %0d %h want %b %0d %h", i,
                 o_scrub_valid, o_scrub_addr, o_scrub_code, m_scrub_v, m_scrub_addr, m_scrub_code);
      end
`endif
    end
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);
  endtask

  task automatic test_reset_mid();
    logic [11:0] c;
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      c = model_encode(8'($urandom));
      c[i + 2] = ~c[i + 2];
      step(1, c, 5'(i + 1), 0, 0);
    end
    checks++;
    if (o_valid !== 1'b1 || o_corr_cnt !== m_corr) begin
      errors++; $display("[TB] FAIL rstmid_pre got v=%b cnt=%0d want 1 %0d", o_valid, o_corr_cnt, m_corr);
    end
    i_valid = 1'b1;
    i_code  = 12'h5A5;
    i_addr  = 5'd9;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({o_valid, o_data, o_addr, o_err_corr, o_err_uncorr, o_corr_cnt, o_uncorr_cnt, o_overflow} !== 49'h0) begin
      errors++;
      $display("[TB] FAIL rstmid_out got v=%b d=%h a=%h c=%b u=%b cc=%h uc=%h o=%b want all 0",
               o_valid, o_data, o_addr, o_err_corr, o_err_uncorr, o_corr_cnt, o_uncorr_cnt, o_overflow);
    end
    i_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 12'hA27, 5'd3, 1, 0);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL rstmid_latency got o_valid=%b want 0", o_valid);
    end
    step(0, 0, 0, 1, 0);
    checks++;
    if ({o_valid, o_data, o_addr} !== {1'b1, 8'hA5, 5'd3}) begin
      errors++; $display("[TB] FAIL rstmid_first got v=%b d=%h a=%0d want 1 a5 3", o_valid, o_data, o_addr);
    end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_saturation();
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 65535; i++) step(1, 12'hA07, 5'd5, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    checks++;
    if (o_corr_cnt !== 16'hFFFF || m_corr !== 16'hFFFF) begin
      errors++; $display("[TB] FAIL sat_reach got %h want ffff", o_corr_cnt);
    end
    step(1, 12'hA07, 5'd5, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    checks++;
    if (o_corr_cnt !== 16'hFFFF) begin
      errors++; $display("[TB] FAIL sat_hold got %h want ffff", o_corr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_err();
    test_uncorr();
    test_overflow();
    test_full_pop();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ecc_read_decoder.md
Name: ecc_read_decoder

Overview:
- Downstream consumer of one dual-port memory read port. Accepts the fixed-latency 12-bit Hamming(12,8) codeword returned by the memory, together with its 5-bit address.
- Performs single-error correction and flags uncorrectable syndromes.
- Buffers results in a small FIFO and presents them on a valid/ready interface. The memory cannot stall, so the input side has no ready.
- Keeps saturating error statistics for the verification scoreboard and for software.

Parameters:
- WIDTH, 8, data width (fixed by the Hamming(12,8) mapping; other values unsupported)
- CODE_WIDTH, 12, codeword width
- ADDR_WIDTH, 5, address width carried alongside each read
- FIFO_DEPTH, 4, output buffer entries (power of two, >=2)
- CNT_WIDTH, 16, width of each error counter

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  codeword valid from memory read port
- i_code  in  CODE_WIDTH  codeword from memory
- i_addr  in  ADDR_WIDTH  address of the returned word
- i_clr_cnt  in  1  synchronous clear of counters and overflow flag
- o_valid  out  1  output entry available
- i_ready  in  1  consumer accepts entry
- o_data  out  WIDTH  corrected data
- o_addr  out  ADDR_WIDTH  address of entry
- o_err_corr  out  1  entry had a corrected single-bit error
- o_err_uncorr  out  1  entry had an uncorrectable syndrome
- o_corr_cnt  out  CNT_WIDTH  corrected-error count
- o_uncorr_cnt  out  CNT_WIDTH  uncorrectable-error count
- o_overflow  out  1  sticky: a result was dropped because the FIFO was full

Behaviour:
- Codeword mapping: i_code[k-1] = Hamming position k (1..12). Parity bits sit at positions 1, 2, 4, 8; even parity.
- Data mapping: data[7:0] = positions {12,11,10,9,7,6,5,3}.
- Syndrome s[3:0] = XOR of the indices of all set positions.
  - s=0: clean.
  - 1<=s<=12: flip position s. Set corr; data bits change only if s is a data position.
  - s>=13: set uncorr; pass data bits raw.
- Stage 1 (edge T0, i_valid=1): register i_code, i_addr and the syndrome.
- Stage 2 (edge T1): apply the correction and write {data, addr, corr, uncorr} into the FIFO.
- Latency: o_valid rises after T1 when the FIFO was empty. There is no bypass.
- Back-to-back: one result per cycle, sustained.
- FIFO handshake: pop when o_valid && i_ready. Output fields are stable while o_valid=1 and i_ready=0.
- Full FIFO at stage-2 write:
  - With a same-cycle pop: the write is accepted.
  - Without a pop: the result is dropped and o_overflow is set. Counters still update.
- Counters:
  - Increment at stage 2 on corr or uncorr, regardless of the FIFO drop.
  - Saturate at all-ones.
  - i_clr_cnt clears both counters and o_overflow. Clear wins over a same-cycle increment.
- Reset (asynchronous, any time, including mid-pipeline):
  - Pipeline and FIFO are emptied.
  - o_valid=0, o_data=0, o_addr=0, o_err_corr=0, o_err_uncorr=0.
  - Counters=0, o_overflow=0.
  - In-flight words are lost.

Optional Feature:
- Macro: ECC_SCRUB_REQ_EN.
- When defined, three outputs are added:
  - o_scrub_valid (1)
  - o_scrub_addr (ADDR_WIDTH)
  - o_scrub_code (CODE_WIDTH)
- o_scrub_valid pulses for one cycle at stage 2 for every corrected error. The pulse occurs even when the FIFO drops the entry.
- o_scrub_addr and o_scrub_code carry the address and the fully corrected codeword, with parity recomputed, for write-back into the memory.
- The scrub outputs reset to 0. No pulse is issued for uncorrectable or clean words.
- When undefined, these ports and their logic are absent, and the behaviour is otherwise identical.

Test Plan:
- Clean read: i_code=0xA27, i_addr=5, i_ready=1 -> two cycles later o_valid=1, o_data=0xA5, o_addr=5, no error flags, counters unchanged.
- Single-bit error: i_code=0xA07 (position 6 flipped) -> o_data=0xA5, o_err_corr=1, o_corr_cnt=1. With ECC_SCRUB_REQ_EN: one o_scrub_valid pulse with o_scrub_code=0xA27, o_scrub_addr=5.
- Uncorrectable: i_code=0xB07 (s=15) -> o_data=0xB1 (raw), o_err_uncorr=1, o_uncorr_cnt=1, no scrub pulse.
- Back-pressure/overflow: i_ready=0, 6 consecutive valid words at FIFO_DEPTH=4 -> first 4 retained in order, o_overflow=1. Then i_ready=1 -> exactly 4 entries drain. i_clr_cnt -> o_overflow=0.
- Full plus simultaneous pop: FIFO full, i_ready=1 on the cycle a new result arrives -> result accepted, no overflow, ordering preserved.
- Reset mid-operation: i_rst_n low with 2 words in flight and 3 in the FIFO -> all outputs and counters 0 immediately. After release, the first new word emerges with 2-cycle latency. Separately, preload o_corr_cnt to 0xFFFF and inject one more error -> counter holds 0xFFFF.
